// File: rtl/load_store_unit_pkg.sv
// Shared core package: funct3 size codes, LSU state encoding, ALU selects, LSU helpers.
package load_store_unit_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned STRB_W = XLEN / 8;

    // RV32I load/store size and sign codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } lsu_state_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_sel_t;

    // Attributes of an accepted request that are still needed after the start cycle
    typedef struct packed {
        logic       is_store;
        logic [2:0] funct3;
        logic [1:0] lane;
    } lsu_req_t;

    // Encodable operation for the given direction
    function automatic logic lsu_legal(input logic is_store, input logic [2:0] funct3);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Half-word on an odd byte, or word off a word boundary
    function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
        logic mis;
        mis = 1'b0;
        case (funct3)
            F3_H, F3_HU: mis = lane[0];
            F3_W:        mis = (lane != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Byte-lane write enables for a store
    function automatic logic [STRB_W-1:0] lsu_wstrb(input logic [2:0] funct3, input logic [1:0] lane);
        logic [STRB_W-1:0] s;
        case (funct3)
            F3_B:    s = STRB_W'(4'b0001 << lane);
            F3_H:    s = STRB_W'(4'b0011 << lane);
            default: s = STRB_W'(4'b1111);
        endcase
        return s;
    endfunction

    // Replicate store data across all lanes so the strobes pick the right copy
    function automatic logic [XLEN-1:0] lsu_wdata(input logic [2:0] funct3, input logic [XLEN-1:0] d);
        logic [XLEN-1:0] w;
        case (funct3)
            F3_B:    w = {4{d[7:0]}};
            F3_H:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Load alignment: picks the addressed byte/half-word from a memory word and extends it.
module load_extend
    import load_store_unit_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      lane,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection followed by sign or zero extension
    always_comb begin
        w_byte = 8'h00;
        w_half = 16'h0000;
        result = word;
        case (lane)
            2'd0:    w_byte = word[7:0];
            2'd1:    w_byte = word[15:8];
            2'd2:    w_byte = word[23:16];
            default: w_byte = word[31:24];
        endcase
        w_half = lane[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    result = {{24{w_byte[7]}}, w_byte};
            F3_H:    result = {{16{w_half[15]}}, w_half};
            F3_BU:   result = {24'h000000, w_byte};
            F3_HU:   result = {16'h0000, w_half};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding access, request/ack memory port, timeout abort.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [XLEN-1:0]   rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ack
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    lsu_state_t       r_state;
    lsu_req_t         r_req;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  w_load_result;
    logic             w_accept;

    // Load data path works on the captured lane/size and the live ack data
    load_extend u_load_extend (
        .word   (mem_rdata),
        .lane   (r_req.lane),
        .funct3 (r_req.funct3),
        .result (w_load_result)
    );

    // Request is issued to memory only if encodable and naturally aligned
    assign w_accept = lsu_legal(is_store, funct3) && !lsu_misaligned(funct3, addr[1:0]);

    // Control FSM with all outputs registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_req     <= '0;
            r_cnt     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wstrb <= '0;
            mem_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_req <= '{is_store: is_store, funct3: funct3, lane: addr[1:0]};
                        r_cnt <= '0;
                        busy  <= 1'b1;
                        if (w_accept) begin
                            r_state   <= ST_ACCESS;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr[XLEN-1:2], 2'b00};
                            mem_wstrb <= is_store ? lsu_wstrb(funct3, addr[1:0]) : '0;
                            mem_wdata <= is_store ? lsu_wdata(funct3, wdata) : '0;
                        end else begin
                            r_state <= ST_DONE;
                            done    <= 1'b1;
                            err     <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (mem_ack) begin
                        r_state   <= ST_DONE;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= '0;
                        done      <= 1'b1;
                        err       <= 1'b0;
                        if (!r_req.is_store) begin
                            rdata <= w_load_result;
                        end
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_state   <= ST_DONE;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= '0;
                        done      <= 1'b1;
                        err       <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    err     <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    err     <= 1'b0;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a scoreboard of expected completions.
module tb_load_store_unit;

    localparam int unsigned TIMEOUT = 16;
    localparam int          NEVER   = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_rdata;
    int          n_cmp  = 0;
    int          n_fail = 0;

    load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_store  (is_store),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic m_legal(input logic st, input logic [2:0] f3);
        if (st) return (f3 <= 3'd2);
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    function automatic logic m_misal(input logic [2:0] f3, input logic [1:0] a);
        return ((f3[1:0] == 2'd1) && a[0]) || ((f3[1:0] == 2'd2) && (a != 2'd0));
    endfunction

    function automatic logic [31:0] m_ext(input logic [31:0] w, input logic [1:0] a, input logic [2:0] f3);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (b[7]  ? 32'hFFFFFF00 : 32'h0) | b;
            3'd1:    return (h[15] ? 32'hFFFF0000 : 32'h0) | h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [1:0] a);
        if (f3 == 3'd0) return 4'(1 << a);
        if (f3 == 3'd1) return 4'(3 << a);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3 == 3'd0) return d[7:0] * 32'h01010101;
        if (f3 == 3'd1) return d[15:0] * 32'h00010001;
        return d;
    endfunction

    // One access: push expectation, start it, serve ack after ack_after mem_req cycles, check completion
    task automatic run_op(input string tag, input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int ack_after, input logic [31:0] word,
                          input logic pulse_busy);
        exp_t e;
        logic ok_acc;
        logic req_ok;
        logic seen;
        int   k;
        ok_acc = m_legal(st, f3) && !m_misal(f3, a[1:0]);
        e.err  = !ok_acc || (ack_after >= int'(TIMEOUT));
        if (!e.err && !st) model_rdata = m_ext(word, a[1:0], f3);
        e.rdata = model_rdata;
        e.lat   = !ok_acc ? 1 : ((ack_after < int'(TIMEOUT)) ? ack_after + 2 : int'(TIMEOUT) + 1);
        sb.push_back(e);

        @(negedge clk);
        is_store = st; funct3 = f3; addr = a; wdata = wd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_req_first"}, 32'(mem_req), 32'(ok_acc));
        if (ok_acc) begin
            chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
            chk({tag, "_we"}, 32'(mem_we), 32'(st));
            chk({tag, "_wstrb"}, 32'(mem_wstrb), st ? 32'(m_strb(f3, a[1:0])) : 32'h0);
            if (st) chk({tag, "_wdata"}, mem_wdata, m_wdata(f3, wd));
        end

        k = 1; req_ok = 1'b1; seen = 1'b0;
        while (k <= 40) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (!mem_req) req_ok = 1'b0;
            mem_ack   = (k == ack_after + 1);
            mem_rdata = word;
            start     = pulse_busy && (k == 5);
            if (start) begin
                addr = a ^ 32'h0000_1000;
                funct3 = 3'd2;
            end
            @(negedge clk);
            k++;
        end
        mem_ack = 1'b0;
        start   = 1'b0;

        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            e = sb.pop_front();
            chk({tag, "_latency"}, 32'(k), 32'(e.lat));
            chk({tag, "_err"}, 32'(err), 32'(e.err));
            chk({tag, "_rdata"}, rdata, e.rdata);
            chk({tag, "_req_at_done"}, 32'(mem_req), 32'd0);
            if (ok_acc) chk({tag, "_addr_at_done"}, mem_addr, {a[31:2], 2'b00});
        end else begin
            void'(sb.pop_front());
        end
        chk({tag, "_req_held"}, 32'(req_ok), 32'd1);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 32'({done, busy}), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = '0; wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0; model_rdata = '0;

        @(negedge clk);
        chk("rst_ctrl", 32'({busy, done, err, mem_req, mem_we, mem_wstrb}), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("lw_100",   1'b0, 3'd2, 32'h100, 32'h0, 3, 32'hDEADBEEF, 1'b0);
        run_op("lb_103",   1'b0, 3'd0, 32'h103, 32'h0, 0, 32'h80112233, 1'b0);
        run_op("lbu_103",  1'b0, 3'd4, 32'h103, 32'h0, 1, 32'h80112233, 1'b0);
        run_op("lh_102",   1'b0, 3'd1, 32'h102, 32'h0, 2, 32'h80112233, 1'b0);
        run_op("lhu_100",  1'b0, 3'd5, 32'h100, 32'h0, 0, 32'h80112233, 1'b0);
        run_op("sh_202",   1'b1, 3'd1, 32'h202, 32'h0000ABCD, 1, 32'h55555555, 1'b0);
        run_op("sb_201",   1'b1, 3'd0, 32'h201, 32'h12345678, 0, 32'h55555555, 1'b0);
        run_op("sw_204",   1'b1, 3'd2, 32'h204, 32'hCAFEF00D, 2, 32'h55555555, 1'b0);
        run_op("lw_mis",   1'b0, 3'd2, 32'h101, 32'h0, 0, 32'h11111111, 1'b0);
        run_op("sw_mis",   1'b1, 3'd2, 32'h206, 32'h1, 0, 32'h11111111, 1'b0);
        run_op("ld_f3_3",  1'b0, 3'd3, 32'h108, 32'h0, 0, 32'h22222222, 1'b0);
        run_op("st_f3_4",  1'b1, 3'd4, 32'h108, 32'h0, 0, 32'h22222222, 1'b0);
        run_op("lw_tmo",   1'b0, 3'd2, 32'h400, 32'h0, NEVER, 32'h33333333, 1'b1);
        run_op("lw_last",  1'b0, 3'd2, 32'h500, 32'h0, int'(TIMEOUT) - 1, 32'h0BADF00D, 1'b0);

        // Reset in the middle of an access, then a stray ack
        @(negedge clk);
        is_store = 1'b0; funct3 = 3'd2; addr = 32'h300; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rstmid_req_before", 32'(mem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmid_req_now", 32'(mem_req), 32'd0);
        chk("rstmid_busy_now", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h77777777;
        model_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstmid_stray_ack", 32'({done, busy, mem_req}), 32'd0);
        end
        mem_ack = 1'b0;
        chk("rstmid_rdata", rdata, model_rdata);

        run_op("lw_after", 1'b0, 3'd2, 32'h010, 32'h0, 2, 32'h13579BDF, 1'b0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
